// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the two-client FP multiplier arbiter.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic [31:0] fp32_t;
    typedef logic [2:0]  rmode_t;

    localparam rmode_t RNE = 3'd0;
    localparam rmode_t RTZ = 3'd1;
    localparam rmode_t RDN = 3'd2;
    localparam rmode_t RUP = 3'd3;
    localparam rmode_t RMM = 3'd4;

endpackage

// File: rtl/fp_mul_arbiter_rr_arb2.sv
// Two-input round-robin grant: the requester that did not win last time has priority.
module rr_arb2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_gnt0,
    output logic o_gnt1
);

    assign o_gnt0 = i_valid0 && (!i_valid1 || i_last_grant);
    assign o_gnt1 = i_valid1 && (!i_valid0 || !i_last_grant);

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one fp_mul datapath between two valid/ready clients, one operation in flight,
// with fixed-latency result capture and sticky overflow/underflow status.
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    input  logic [2:0]  req0_rmode,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    input  logic [2:0]  req1_rmode,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_z,
    output logic        rsp0_ovrf,
    output logic        rsp0_udrf,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_z,
    output logic        rsp1_ovrf,
    output logic        rsp1_udrf,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    output logic [2:0]  mul_rmode,
    input  logic [31:0] mul_z,
    input  logic        mul_ovrf,
    input  logic        mul_udrf,
    output logic        busy,
    output logic        ovrf_sticky,
    output logic        udrf_sticky,
    input  logic        sticky_clr,
    output logic [1:0]  dbg_state
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MUL_LAT - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;
    logic             r_owner;
    fp32_t            r_x;
    fp32_t            r_y;
    rmode_t           r_rmode;
    fp32_t            r_z;
    logic             r_ovrf;
    logic             r_udrf;
    logic             r_ovrf_sticky;
    logic             r_udrf_sticky;

    logic w_arb_en;
    logic w_gnt0;
    logic w_gnt1;
    logic w_capture;
    logic w_rsp_hs;

    // Grants are only offered in IDLE and never while reset is asserted.
    assign w_arb_en = (r_state == IDLE) && rst_n;

    rr_arb2 u_arb (
        .i_valid0     (req0_valid && w_arb_en),
        .i_valid1     (req1_valid && w_arb_en),
        .i_last_grant (r_last_grant),
        .o_gnt0       (w_gnt0),
        .o_gnt1       (w_gnt1)
    );

    assign w_capture = (r_state == BUSY) && (r_cnt == '0);
    assign w_rsp_hs  = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_last_grant  <= 1'b1;
            r_owner       <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_rmode       <= '0;
            r_z           <= '0;
            r_ovrf        <= 1'b0;
            r_udrf        <= 1'b0;
            r_ovrf_sticky <= 1'b0;
            r_udrf_sticky <= 1'b0;
        end else begin
            // A capture in the same cycle as a clear leaves exactly the captured flags.
            if (w_capture) begin
                r_ovrf_sticky <= (r_ovrf_sticky && !sticky_clr) || mul_ovrf;
                r_udrf_sticky <= (r_udrf_sticky && !sticky_clr) || mul_udrf;
            end else if (sticky_clr) begin
                r_ovrf_sticky <= 1'b0;
                r_udrf_sticky <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_x          <= w_gnt1 ? req1_x : req0_x;
                        r_y          <= w_gnt1 ? req1_y : req0_y;
                        r_rmode      <= w_gnt1 ? req1_rmode : req0_rmode;
                        r_owner      <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_cnt        <= LAT_M1;
                        r_state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_capture) begin
                        r_z     <= mul_z;
                        r_ovrf  <= mul_ovrf;
                        r_udrf  <= mul_udrf;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign rsp0_valid  = (r_state == RESP) && !r_owner;
    assign rsp1_valid  = (r_state == RESP) && r_owner;
    assign rsp0_z      = r_z;
    assign rsp1_z      = r_z;
    assign rsp0_ovrf   = r_ovrf;
    assign rsp1_ovrf   = r_ovrf;
    assign rsp0_udrf   = r_udrf;
    assign rsp1_udrf   = r_udrf;
    assign mul_x       = r_x;
    assign mul_y       = r_y;
    assign mul_rmode   = r_rmode;
    assign busy        = (r_state != IDLE);
    assign ovrf_sticky = r_ovrf_sticky;
    assign udrf_sticky = r_udrf_sticky;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: MUL_LAT=2 main instance plus MUL_LAT=1 and 15 instances.
module tb_fp_mul_arbiter;
    import fp_mul_pkg::*;

    localparam int MAIN_LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic [2:0]  req0_rmode, req1_rmode;
    logic        rsp0_valid, rsp0_ready, rsp0_ovrf, rsp0_udrf;
    logic        rsp1_valid, rsp1_ready, rsp1_ovrf, rsp1_udrf;
    logic [31:0] rsp0_z, rsp1_z;
    logic [31:0] mul_x, mul_y, mul_z;
    logic [2:0]  mul_rmode;
    logic        mul_ovrf, mul_udrf;
    logic        busy, ovrf_sticky, udrf_sticky, sticky_clr;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference multiplier: flush subnormals, truncate, saturate exponent range into flags.
    function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [47:0] m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return {2'b00, s, 31'd0};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = ea + eb - 127;
        if (m[47]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0) return {2'b01, s, 31'd0};
        return {2'b00, s, e[7:0], m[45:23]};
    endfunction

    assign {mul_ovrf, mul_udrf, mul_z} = fmul(mul_x, mul_y);

    fp_mul_arbiter #(.MUL_LAT(MAIN_LAT), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req0_rmode(req0_rmode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .req1_rmode(req1_rmode),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z), .rsp0_ovrf(rsp0_ovrf),
        .rsp0_udrf(rsp0_udrf),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z), .rsp1_ovrf(rsp1_ovrf),
        .rsp1_udrf(rsp1_udrf),
        .mul_x(mul_x), .mul_y(mul_y), .mul_rmode(mul_rmode), .mul_z(mul_z),
        .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf),
        .busy(busy), .ovrf_sticky(ovrf_sticky), .udrf_sticky(udrf_sticky),
        .sticky_clr(sticky_clr), .dbg_state(dbg_state)
    );

    // Latency sweep instances: index 0 -> MUL_LAT=1, index 1 -> MUL_LAT=15.
    logic        s_valid[2], s_ready[2], s_rsp_valid[2], s_busy[2];
    logic [31:0] s_x[2], s_y[2], s_mul_x[2], s_mul_y[2], s_mul_z[2], s_rsp_z[2];
    logic        s_mul_ovrf[2], s_mul_udrf[2];
    logic [2:0]  s_mul_rmode[2];
    logic        s_r1_ready[2], s_rsp1_valid[2], s_o0[2], s_u0[2], s_o1[2], s_u1[2];
    logic        s_ovs[2], s_uds[2];
    logic [31:0] s_rsp1_z[2];
    logic [1:0]  s_dbg[2];

    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int LAT = (g == 0) ? 1 : 15;
        assign {s_mul_ovrf[g], s_mul_udrf[g], s_mul_z[g]} = fmul(s_mul_x[g], s_mul_y[g]);
        fp_mul_arbiter #(.MUL_LAT(LAT), .CNT_W(4)) u_sw (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(s_valid[g]), .req0_ready(s_ready[g]), .req0_x(s_x[g]), .req0_y(s_y[g]),
            .req0_rmode(RNE),
            .req1_valid(1'b0), .req1_ready(s_r1_ready[g]), .req1_x(32'd0), .req1_y(32'd0),
            .req1_rmode(3'd0),
            .rsp0_valid(s_rsp_valid[g]), .rsp0_ready(1'b1), .rsp0_z(s_rsp_z[g]), .rsp0_ovrf(s_o0[g]),
            .rsp0_udrf(s_u0[g]),
            .rsp1_valid(s_rsp1_valid[g]), .rsp1_ready(1'b1), .rsp1_z(s_rsp1_z[g]),
            .rsp1_ovrf(s_o1[g]), .rsp1_udrf(s_u1[g]),
            .mul_x(s_mul_x[g]), .mul_y(s_mul_y[g]), .mul_rmode(s_mul_rmode[g]),
            .mul_z(s_mul_z[g]), .mul_ovrf(s_mul_ovrf[g]), .mul_udrf(s_mul_udrf[g]),
            .busy(s_busy[g]), .ovrf_sticky(s_ovs[g]), .udrf_sticky(s_uds[g]),
            .sticky_clr(1'b0), .dbg_state(s_dbg[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_rmode = '0;
        req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_rmode = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1; sticky_clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0; s_x[i] = '0; s_y[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one request on port p and waits for its response valid (sampled at negedges).
    task automatic issue(input int p, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] rm, input bit clr_cap, output int wait_n,
                         output int lat, output logic [31:0] z, output logic ov,
                         output logic ud, output bit other_seen);
        @(negedge clk);
        if (p == 0) begin
            req0_x = x; req0_y = y; req0_rmode = rm; req0_valid = 1'b1;
        end else begin
            req1_x = x; req1_y = y; req1_rmode = rm; req1_valid = 1'b1;
        end
        #1;
        wait_n = 0;
        while (((p == 0) ? req0_ready : req1_ready) !== 1'b1 && wait_n < 20) begin
            @(negedge clk); #1;
            wait_n++;
        end
        @(negedge clk);
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        lat = 0;
        other_seen = 1'b0;
        while (((p == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 && lat < 40) begin
            if (((p == 0) ? rsp1_valid : rsp0_valid) !== 1'b0) other_seen = 1'b1;
            if (clr_cap && lat == MAIN_LAT - 1) sticky_clr = 1'b1;
            @(negedge clk);
            sticky_clr = 1'b0;
            lat++;
        end
        z  = (p == 0) ? rsp0_z : rsp1_z;
        ov = (p == 0) ? rsp0_ovrf : rsp1_ovrf;
        ud = (p == 0) ? rsp0_udrf : rsp1_udrf;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        do_reset();
        got = {rsp0_z[15:0], mul_x[7:0], mul_y[3:0], req0_ready, req1_ready, rsp0_valid,
               rsp1_valid, busy, ovrf_sticky, udrf_sticky, mul_rmode[0]};
        n_tests++;
        if (got !== 32'd0 || rsp0_z !== 32'd0 || mul_x !== 32'd0 || mul_y !== 32'd0 ||
            mul_rmode !== 3'd0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", got);
        end
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single_op();
        int w, lat; logic [31:0] z; logic ov, ud; bit other;
        do_reset();
        issue(0, 32'h40000000, 32'h40400000, RNE, 1'b0, w, lat, z, ov, ud, other);
        n_tests++;
        if (w !== 0) begin n_fail++; $display("FAIL single_ready_cycle: got %0d expected 0", w); end
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 2", lat); end
        n_tests++;
        if ({ov, ud, z} !== {2'b00, 32'h40C00000}) begin
            n_fail++;
            $display("FAIL single_result: got %b %b %h expected 0 0 40c00000", ov, ud, z);
        end
        n_tests++;
        if (other !== 1'b0 || rsp1_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rsp1_quiet: got %b expected 0", other | rsp1_valid);
        end
    endtask

    task automatic test_contention();
        int g_port[$];
        int g_cyc[$];
        int cyc;
        do_reset();
        @(negedge clk);
        req0_x = 32'h40000000; req0_y = 32'h40400000; req0_rmode = RNE; req0_valid = 1'b1;
        req1_x = 32'h3F800000; req1_y = 32'h40800000; req1_rmode = RTZ; req1_valid = 1'b1;
        cyc = 0;
        while (g_port.size() < 4 && cyc < 60) begin
            #1;
            if (req0_ready && req1_ready) begin
                n_tests++; n_fail++;
                $display("FAIL both_ready: got 11 expected at most one");
            end
            if (req0_ready) begin g_port.push_back(0); g_cyc.push_back(cyc); end
            if (req1_ready) begin g_port.push_back(1); g_cyc.push_back(cyc); end
            if (rsp0_valid) begin
                n_tests++;
                if (rsp0_z !== 32'h40C00000 || rsp1_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL route_rsp0: got %h/%b expected 40c00000/0", rsp0_z, rsp1_valid);
                end
            end
            if (rsp1_valid) begin
                n_tests++;
                if (rsp1_z !== 32'h40800000 || rsp0_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL route_rsp1: got %h/%b expected 40800000/0", rsp1_z, rsp0_valid);
                end
            end
            @(negedge clk);
            cyc++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_tests++;
        if (g_port.size() != 4) begin
            n_fail++;
            $display("FAIL grant_count: got %0d expected 4", g_port.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (g_port[i] != (i % 2)) begin
                    n_fail++;
                    $display("FAIL grant_order[%0d]: got %0d expected %0d", i, g_port[i], i % 2);
                end
            end
            n_tests++;
            if (g_cyc[1] - g_cyc[0] != MAIN_LAT + 2 || g_cyc[3] - g_cyc[2] != MAIN_LAT + 2) begin
                n_fail++;
                $display("FAIL issue_interval: got %0d expected %0d", g_cyc[1] - g_cyc[0], MAIN_LAT + 2);
            end
        end
    endtask

    task automatic test_back_pressure();
        int w, lat; logic [31:0] z; logic ov, ud; bit other;
        do_reset();
        rsp1_ready = 1'b0;
        issue(1, 32'h3F800000, 32'h40800000, RTZ, 1'b0, w, lat, z, ov, ud, other);
        n_tests++;
        if (z !== 32'h40800000 || lat !== 2) begin
            n_fail++;
            $display("FAIL bp_result: got %h lat %0d expected 40800000 lat 2", z, lat);
        end
        req0_x = 32'h40000000; req0_y = 32'h40000000; req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_tests++;
            if ({rsp1_valid, rsp0_valid, req0_ready, busy} !== 4'b1001 || rsp1_z !== 32'h40800000 ||
                mul_rmode !== RTZ) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v1 %b v0 %b rdy0 %b busy %b z %h expected 1 0 0 1 40800000",
                         i, rsp1_valid, rsp0_valid, req0_ready, busy, rsp1_z);
            end
            @(negedge clk);
        end
        rsp1_ready = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if ({busy, rsp1_valid, req0_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL bp_release: got busy %b v1 %b rdy0 %b expected 0 0 1", busy, rsp1_valid, req0_ready);
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_special_values();
        int w, lat; logic [31:0] z; logic ov, ud; bit other;
        do_reset();
        issue(0, 32'h00000001, 32'h3F800000, RNE, 1'b0, w, lat, z, ov, ud, other);
        n_tests++;
        if (z[30:0] !== 31'd0) begin n_fail++; $display("FAIL subnormal_flush: got %h expected 0", z); end
        issue(0, 32'h7F000000, 32'h7F000000, RNE, 1'b0, w, lat, z, ov, ud, other);
        n_tests++;
        if (ov !== 1'b1) begin n_fail++; $display("FAIL ovrf_flag: got %b expected 1", ov); end
        @(negedge clk);
        n_tests++;
        if ({ovrf_sticky, udrf_sticky} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovrf_sticky_set: got %b expected 10", {ovrf_sticky, udrf_sticky});
        end
        issue(0, 32'h40000000, 32'h40400000, RNE, 1'b1, w, lat, z, ov, ud, other);
        n_tests++;
        if (ovrf_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_with_clean_capture: got %b expected 0", ovrf_sticky);
        end
        issue(0, 32'h7F000000, 32'h7F000000, RNE, 1'b1, w, lat, z, ov, ud, other);
        n_tests++;
        if (ovrf_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL capture_beats_clr: got %b expected 1", ovrf_sticky);
        end
        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0; #1;
        n_tests++;
        if (ovrf_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clr: got %b expected 0", ovrf_sticky); end
        issue(1, 32'h00800000, 32'h00800000, RNE, 1'b0, w, lat, z, ov, ud, other);
        @(negedge clk);
        n_tests++;
        if ({ud, udrf_sticky, ovrf_sticky} !== 3'b110 || z[30:0] !== 31'd0) begin
            n_fail++;
            $display("FAIL udrf: got %b%b%b z %h expected 110 z 0", ud, udrf_sticky, ovrf_sticky, z);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit seen;
        do_reset();
        req0_x = 32'h40000000; req0_y = 32'h40400000; req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0; #1;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %b expected 1", busy); end
        rst_n = 1'b0; #1;
        n_tests++;
        if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'd0 || mul_x !== 32'd0 ||
            mul_y !== 32'd0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: got busy %b mul_x %h expected 0 0", busy, mul_x);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL stale_response: got 1 expected 0"); end
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_latency_sweep();
        do_reset();
        for (int g = 0; g < 2; g++) begin
            int  lat_exp;
            int  n;
            bit  stable;
            lat_exp = (g == 0) ? 1 : 15;
            @(negedge clk);
            s_x[g] = 32'h40000000; s_y[g] = 32'h40400000; s_valid[g] = 1'b1; #1;
            n_tests++;
            if (s_ready[g] !== 1'b1) begin n_fail++; $display("FAIL sweep_ready[%0d]: got %b expected 1", g, s_ready[g]); end
            @(negedge clk);
            s_valid[g] = 1'b0; s_x[g] = 32'h0; s_y[g] = 32'h0;
            n = 0; stable = 1'b1;
            while (s_rsp_valid[g] !== 1'b1 && n < 40) begin
                if (s_mul_x[g] !== 32'h40000000 || s_mul_y[g] !== 32'h40400000 || s_busy[g] !== 1'b1)
                    stable = 1'b0;
                @(negedge clk);
                n++;
            end
            n_tests++;
            if (n != lat_exp) begin n_fail++; $display("FAIL sweep_latency[%0d]: got %0d expected %0d", g, n, lat_exp); end
            n_tests++;
            if (!stable) begin n_fail++; $display("FAIL sweep_operand_hold[%0d]: got unstable expected stable", g); end
            n_tests++;
            if (s_rsp_z[g] !== 32'h40C00000) begin n_fail++; $display("FAIL sweep_result[%0d]: got %h expected 40c00000", g, s_rsp_z[g]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_back_pressure();
        test_special_values();
        test_reset_mid_busy();
        test_latency_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
